multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 147 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle fetch/decode/execute control sequencer
// Optional retired-instruction counter enabled by defining SEQ_RETIRE_CNT_EN.
module multicycle_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] opcode,
  input  logic       mem_ready,
  output logic       fetch_req,
  output logic       ir_load,
  output logic       pc_en,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       ALUSrc,
  output logic       busy,
  output logic       err,
  output logic [2:0] state
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [7:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    SPARE  = 3'd6,
    ERR    = 3'd7
  } stateT;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  stateT      curState;
  stateT      nextState;
  stateT      retireState;
  logic [7:0] waitCnt;
  logic       waitExpired;
  logic       isMemOp;

  // waitCnt holds the low cycles already seen, so this is the last tolerated one
  assign waitExpired = (waitCnt >= WAIT_LAST);
  assign retireState = run ? FETCH : IDLE;
  assign isMemOp     = (opcode == 2'b01) || (opcode == 2'b10);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      curState <= IDLE;
    end else begin
      curState <= nextState;
    end
  end

  // Any state change clears the counter, which covers entry to FETCH and MEM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waitCnt <= 8'd0;
    end else if (nextState != curState) begin
      waitCnt <= 8'd0;
    end else if (((curState == FETCH) || (curState == MEM)) && !mem_ready) begin
      waitCnt <= waitCnt + 8'd1;
    end
  end

  always_comb begin
    nextState = curState;
    fetch_req = 1'b0;
    ir_load   = 1'b0;
    pc_en     = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    ALUSrc    = 1'b0;
    case (curState)
      IDLE: begin
        if (run) nextState = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (mem_ready) begin
          ir_load   = 1'b1;
          pc_en     = 1'b1;
          nextState = DECODE;
        end else if (waitExpired) begin
          nextState = ERR;
        end
      end
      DECODE: begin
        nextState = EXEC;
      end
      EXEC: begin
        ALUSrc    = (opcode != 2'b00);
        nextState = isMemOp ? MEM : WB;
      end
      MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = (opcode == 2'b01);
        MemWrite = (opcode == 2'b10);
        if (mem_ready) begin
          nextState = (opcode == 2'b01) ? WB : retireState;
        end else if (waitExpired) begin
          nextState = ERR;
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        ALUSrc    = (opcode != 2'b00);
        nextState = retireState;
      end
      ERR: begin
        nextState = ERR;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign busy  = (curState != IDLE) && (curState != ERR);
  assign err   = (curState == ERR);
  assign state = curState;

`ifdef SEQ_RETIRE_CNT_EN
  logic       retiring;
  logic [7:0] retiredCnt;

  assign retiring = (curState == WB) ||
                    ((curState == MEM) && mem_ready && (opcode != 2'b01));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retiredCnt <= 8'd0;
    end else if (retiring) begin
      retiredCnt <= retiredCnt + 8'd1;
    end
  end

  assign retired_cnt = retiredCnt;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed vector bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [1:0] opcode;
  logic       mem_ready;
  logic       fetch_req, ir_load, pc_en, RegWrite, MemWrite, MemRead, ALUSrc, busy, err;
  logic [2:0] state;
`ifdef SEQ_RETIRE_CNT_EN
  logic [7:0] retiredCnt;
`endif

  int compared = 0;
  int mismatched = 0;

  multicycle_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .fetch_req (fetch_req),
    .ir_load   (ir_load),
    .pc_en     (pc_en),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ALUSrc    (ALUSrc),
    .busy      (busy),
    .err       (err),
    .state     (state)
`ifdef SEQ_RETIRE_CNT_EN
    ,
    .retired_cnt (retiredCnt)
`endif
  );

  always #5 clk = ~clk;

  // Control bit order: fetch_req ir_load pc_en RegWrite MemWrite MemRead ALUSrc busy err
  localparam logic [8:0] C_ZERO   = 9'b000000000;
  localparam logic [8:0] C_FGO    = 9'b111000010;
  localparam logic [8:0] C_FWAIT  = 9'b100000010;
  localparam logic [8:0] C_BUSY   = 9'b000000010;
  localparam logic [8:0] C_EXIMM  = 9'b000000110;
  localparam logic [8:0] C_WBREG  = 9'b000100010;
  localparam logic [8:0] C_WBIMM  = 9'b000100110;
  localparam logic [8:0] C_MEMRD  = 9'b000001110;
  localparam logic [8:0] C_MEMWR  = 9'b000010110;
  localparam logic [8:0] C_ERR    = 9'b000000001;

  typedef struct {
    logic       rstN;
    logic       run;
    logic [1:0] op;
    logic       mr;
    logic [2:0] expState;
    logic [8:0] expCtl;
  } vecT;

  vecT vecs[30];

  task automatic drive(input logic r, input logic rn, input logic [1:0] op, input logic mr);
    @(negedge clk);
    rst_n     = r;
    run       = rn;
    opcode    = op;
    mem_ready = mr;
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] expState, input logic [8:0] expCtl);
    logic [11:0] got;
    logic [11:0] exp;
    got = {state, fetch_req, ir_load, pc_en, RegWrite, MemWrite, MemRead, ALUSrc, busy, err};
    exp = {expState, expCtl};
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
               name, got[11:9], got[8:0], exp[11:9], exp[8:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 2'b00; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset", 3'd0, C_ZERO);

    // opcode 00 then 11 back to back, then 01 with waits, 10 with run dropped, reset mid-instruction
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 3'd0, C_ZERO};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd0, C_ZERO};
    vecs[2]  = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd1, C_FGO};
    vecs[3]  = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd2, C_BUSY};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd3, C_BUSY};
    vecs[5]  = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd5, C_WBREG};
    vecs[6]  = '{1'b1, 1'b1, 2'd3, 1'b1, 3'd1, C_FGO};
    vecs[7]  = '{1'b1, 1'b1, 2'd3, 1'b1, 3'd2, C_BUSY};
    vecs[8]  = '{1'b1, 1'b1, 2'd3, 1'b1, 3'd3, C_EXIMM};
    vecs[9]  = '{1'b1, 1'b0, 2'd3, 1'b1, 3'd5, C_WBIMM};
    vecs[10] = '{1'b1, 1'b0, 2'd3, 1'b1, 3'd0, C_ZERO};
    vecs[11] = '{1'b1, 1'b1, 2'd1, 1'b1, 3'd0, C_ZERO};
    vecs[12] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd1, C_FWAIT};
    vecs[13] = '{1'b1, 1'b1, 2'd1, 1'b1, 3'd1, C_FGO};
    vecs[14] = '{1'b1, 1'b1, 2'd1, 1'b1, 3'd2, C_BUSY};
    vecs[15] = '{1'b1, 1'b1, 2'd1, 1'b1, 3'd3, C_EXIMM};
    vecs[16] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd4, C_MEMRD};
    vecs[17] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd4, C_MEMRD};
    vecs[18] = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd4, C_MEMRD};
    vecs[19] = '{1'b1, 1'b1, 2'd1, 1'b1, 3'd4, C_MEMRD};
    vecs[20] = '{1'b1, 1'b1, 2'd1, 1'b1, 3'd5, C_WBIMM};
    vecs[21] = '{1'b1, 1'b1, 2'd2, 1'b1, 3'd1, C_FGO};
    vecs[22] = '{1'b1, 1'b1, 2'd2, 1'b1, 3'd2, C_BUSY};
    vecs[23] = '{1'b1, 1'b0, 2'd2, 1'b1, 3'd3, C_EXIMM};
    vecs[24] = '{1'b1, 1'b0, 2'd2, 1'b1, 3'd4, C_MEMWR};
    vecs[25] = '{1'b1, 1'b0, 2'd2, 1'b1, 3'd0, C_ZERO};
    vecs[26] = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd0, C_ZERO};
    vecs[27] = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd1, C_FGO};
    vecs[28] = '{1'b0, 1'b1, 2'd0, 1'b1, 3'd2, C_BUSY};
    vecs[29] = '{1'b1, 1'b0, 2'd0, 1'b1, 3'd0, C_ZERO};

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].rstN, vecs[i].run, vecs[i].op, vecs[i].mr);
      check($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expCtl);
    end

    // Fetch timeout: 15 low cycles in FETCH, then ERR until reset
    drive(1'b1, 1'b1, 2'd0, 1'b0);
    check("to_idle", 3'd0, C_ZERO);
    for (int k = 1; k <= 15; k++) begin
      drive(1'b1, 1'b1, 2'd0, 1'b0);
      check($sformatf("to_fetch%0d", k), 3'd1, C_FWAIT);
    end
    drive(1'b1, 1'b1, 2'd0, 1'b0);
    check("to_err", 3'd7, C_ERR);
    drive(1'b1, 1'b1, 2'd0, 1'b1);
    check("err_hold", 3'd7, C_ERR);
    drive(1'b0, 1'b1, 2'd0, 1'b1);
    check("err_in_rst", 3'd7, C_ERR);
    drive(1'b1, 1'b0, 2'd0, 1'b1);
    check("err_cleared", 3'd0, C_ZERO);

    // mem_ready on the last tolerated cycle beats the timeout, in FETCH and MEM
    drive(1'b1, 1'b1, 2'd2, 1'b0);
    check("win_idle", 3'd0, C_ZERO);
    for (int k = 1; k <= 14; k++) begin
      drive(1'b1, 1'b1, 2'd2, 1'b0);
      check($sformatf("win_fwait%0d", k), 3'd1, C_FWAIT);
    end
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    check("win_fgo", 3'd1, C_FGO);
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    check("win_decode", 3'd2, C_BUSY);
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    check("win_exec", 3'd3, C_EXIMM);
    for (int k = 1; k <= 14; k++) begin
      drive(1'b1, 1'b1, 2'd2, 1'b0);
      check($sformatf("win_mwait%0d", k), 3'd4, C_MEMWR);
    end
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    check("win_mgo", 3'd4, C_MEMWR);
    drive(1'b1, 1'b1, 2'd2, 1'b1);
    check("win_refetch", 3'd1, C_FGO);
    drive(1'b0, 1'b0, 2'd2, 1'b1);
    check("win_rst", 3'd2, C_BUSY);
    drive(1'b1, 1'b0, 2'd2, 1'b1);
    check("win_idle_end", 3'd0, C_ZERO);

`ifdef SEQ_RETIRE_CNT_EN
    drive(1'b1, 1'b1, 2'd0, 1'b1);
    for (int k = 0; k < 1029; k++) drive(1'b1, 1'b1, 2'd0, 1'b1);
    check("cnt_state", 3'd1, C_FGO);
    compared++;
    if (retiredCnt !== 8'd1) begin
      mismatched++;
      $display("FAIL cnt_wrap: got %0d expected 1", retiredCnt);
    end
    drive(1'b1, 1'b1, 2'd0, 1'b1);
    drive(1'b1, 1'b1, 2'd0, 1'b1);
    drive(1'b0, 1'b1, 2'd0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 1'b1);
    check("cnt_rst_state", 3'd0, C_ZERO);
    compared++;
    if (retiredCnt !== 8'd0) begin
      mismatched++;
      $display("FAIL cnt_rst: got %0d expected 0", retiredCnt);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
